// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: PC-1 on load, per-round C/D rotation, registered
// PC-2 output. Emits K1..K16 (encrypt) or K16..K1 (decrypt), each held for
// ROUND_CYCLES clocks, so it can feed a round datapath of matching latency.
module des_key_schedule #(
  parameter int ROUND_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key,
  input  logic        decrypt,
  output logic [47:0] round_key,
  output logic [3:0]  round_idx,
  output logic        key_valid,
  output logic        last_round,
  output logic        busy,
  output logic        done
);

  localparam int HW = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;

  // FIPS 46-3 PC-1: 1-based source bit numbers of the 64-bit key, output order
  localparam logic [447:0] PC1_TAB = {
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,
    8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
    8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27,
    8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15,
    8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
    8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29,
    8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
  };

  // FIPS 46-3 PC-2: 1-based source bit numbers of the 56-bit C||D, output order
  localparam logic [383:0] PC2_TAB = {
    8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,
    8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
    8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,
    8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
    8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55,
    8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
    8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53,
    8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [27:0]     c, d, load_c, load_d, step_c, step_d;
  logic [55:0]     cd0;
  logic            dec;
  logic            step_two;
  logic [HW-1:0]   hold;
  logic            hold_wrap;

  // Vector bit 63 is FIPS bit 1, so FIPS bit n lives at key[64-n]
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [447:0] t;
    logic [55:0]  cd;
    int           p;
    t  = PC1_TAB;
    cd = '0;
    for (int j = 0; j < 56; j++) begin
      p  = 64 - int'(t[447:440]);
      cd = {cd[54:0], k[p[5:0]]};
      t  = t << 8;
    end
    return cd;
  endfunction

  function automatic logic [47:0] pc2(input logic [27:0] cc, input logic [27:0] dd);
    logic [383:0] t;
    logic [55:0]  cd;
    logic [47:0]  rk;
    int           p;
    t  = PC2_TAB;
    cd = {cc, dd};
    rk = '0;
    for (int j = 0; j < 48; j++) begin
      p  = 56 - int'(t[383:376]);
      rk = {rk[46:0], cd[p[5:0]]};
      t  = t << 8;
    end
    return rk;
  endfunction

  // Shift table entry s(n+1) is 1 for n = 0,1,8,15, otherwise 2
  function automatic logic single_shift(input logic [3:0] n);
    return (n == 4'd0) || (n == 4'd1) || (n == 4'd8) || (n == 4'd15);
  endfunction

  // FIPS bit 1 is the MSB: a left rotate wraps bit 1 round to bit 28
  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  assign hold_wrap = (hold == HW'(ROUND_CYCLES - 1));

  // Load values (encrypt pre-rotates by s1) and the next-slot rotation
  always_comb begin
    cd0 = pc1(key);
    if (decrypt) begin
      load_c = cd0[55:28];
      load_d = cd0[27:0];
    end else begin
      load_c = rotl(cd0[55:28], 1'b0);
      load_d = rotl(cd0[27:0], 1'b0);
    end
    if (dec) begin
      step_two = !single_shift(4'd15 - round_idx);
      step_c   = rotr(c, step_two);
      step_d   = rotr(d, step_two);
    end else begin
      step_two = !single_shift(round_idx + 4'd1);
      step_c   = rotl(c, step_two);
      step_d   = rotl(d, step_two);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (hold_wrap && (round_idx == 4'd15)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy       = (state == RUN);
    key_valid  = (state == RUN);
    last_round = (state == RUN) && (round_idx == 4'd15);
    done       = (state == DONE);
  end

  // Key datapath: load on accepted start, step C/D when a slot's hold expires
  always_ff @(posedge clk) begin
    if (rst) begin
      round_key <= '0;
      round_idx <= '0;
      hold      <= '0;
    end else if (state == IDLE && start) begin
      c         <= load_c;
      d         <= load_d;
      dec       <= decrypt;
      round_idx <= '0;
      hold      <= '0;
      round_key <= pc2(load_c, load_d);
    end else if (state == RUN) begin
      if (hold_wrap) begin
        hold <= '0;
        if (round_idx != 4'd15) begin
          round_idx <= round_idx + 4'd1;
          c         <= step_c;
          d         <= step_d;
          round_key <= pc2(step_c, step_d);
        end
      end else begin
        hold <= hold + HW'(1);
      end
    end
  end

endmodule
